// File: rtl/gauss_pkg.sv
// +--------------------------------------------------------------------------+
// | gauss_pkg                                                                |
// | Shared constants, state encoding and helpers for the Gaussian sampler.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package gauss_pkg;

    localparam int          Q_FRAC       = 28;
    localparam logic [31:0] INV_SQRT_2PI = 32'h06621101;
    localparam int          TRY_W        = 8;
    localparam int          WAIT_W       = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAW_X   = 3'd1,
        EXP_WAIT = 3'd2,
        DRAW_U   = 3'd3,
        CMP      = 3'd4,
        OUT      = 3'd5
    } state_t;

    // Top Q_FRAC bits of the LFSR word become a uniform value in [0,1).
    function automatic logic [31:0] uniform_from_lfsr(input logic [31:0] w);
        return w >> (32 - Q_FRAC);
    endfunction

    function automatic logic [TRY_W-1:0] sat_inc_try(input logic [TRY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gauss_if.sv
// +--------------------------------------------------------------------------+
// | gauss_if                                                                 |
// | LFSR, exp-unit and sample-output signals of the sampler controller.      |
// | Stats outputs exist only when GAUSS_STATS_EN is defined. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface gauss_if;
    logic        gen_en;
    logic [31:0] lfsr_data;
    logic        lfsr_step;
    logic        exp_start;
    logic [31:0] exp_arg;
    logic        exp_done;
    logic [31:0] exp_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_timeout;
    logic        busy;

`ifdef GAUSS_STATS_EN
    logic [31:0] stat_accept;
    logic [31:0] stat_reject;
    logic [15:0] stat_timeout;

    modport master (
        input  gen_en, lfsr_data, exp_done, exp_result, out_ready,
        output lfsr_step, exp_start, exp_arg, out_valid, out_data, out_timeout, busy,
        output stat_accept, stat_reject, stat_timeout
    );
    modport slave (
        output gen_en, lfsr_data, exp_done, exp_result, out_ready,
        input  lfsr_step, exp_start, exp_arg, out_valid, out_data, out_timeout, busy,
        input  stat_accept, stat_reject, stat_timeout
    );
`else
    modport master (
        input  gen_en, lfsr_data, exp_done, exp_result, out_ready,
        output lfsr_step, exp_start, exp_arg, out_valid, out_data, out_timeout, busy
    );
    modport slave (
        output gen_en, lfsr_data, exp_done, exp_result, out_ready,
        input  lfsr_step, exp_start, exp_arg, out_valid, out_data, out_timeout, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/gauss_stats.sv
// +--------------------------------------------------------------------------+
// | gauss_stats                                                              |
// | Saturating accept / reject / timeout event counters. Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module gauss_stats (
    input  wire         clk,
    input  wire         rst,
    input  wire         i_accept,
    input  wire         i_reject,
    input  wire         i_timeout,
    output logic [31:0] o_accept,
    output logic [31:0] o_reject,
    output logic [15:0] o_timeout
);

    logic [31:0] r_accept;
    logic [31:0] r_reject;
    logic [15:0] r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_accept  <= '0;
            r_reject  <= '0;
            r_timeout <= '0;
        end else begin
            if (i_accept && !(&r_accept))
                r_accept <= r_accept + 32'd1;
            if (i_reject && !(&r_reject))
                r_reject <= r_reject + 32'd1;
            if (i_timeout && !(&r_timeout))
                r_timeout <= r_timeout + 16'd1;
        end
    end

    assign o_accept  = r_accept;
    assign o_reject  = r_reject;
    assign o_timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/gauss_sample_ctrl.sv
// +--------------------------------------------------------------------------+
// | gauss_sample_ctrl                                                        |
// | Rejection-sampling sequencer: draws x, evaluates e^(-x^2/2), tests       |
// | against uniform u. Optional counters with GAUSS_STATS_EN. Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module gauss_sample_ctrl
    import gauss_pkg::*;
#(
    parameter int MAX_TRIES = 16,
    parameter int EXP_TMO   = 64
) (
    input  wire     clk,
    input  wire     rst,
    gauss_if.master bus
);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_exp_arg;
    logic [31:0]        r_exp_res;
    logic [31:0]        r_u;
    logic [31:0]        r_out_data;
    logic               r_out_tmo;
    logic [TRY_W-1:0]   r_tries;
    logic [WAIT_W-1:0]  r_wait;

    logic [31:0]        w_x;
    logic               w_tmo;
    logic               w_accept;
    logic [TRY_W-1:0]   w_tries_inc;
    logic               w_exhaust;
    logic               w_lfsr_step;
    logic               w_exp_start;
    logic               w_out_valid;
    logic               w_busy;
    logic [31:0]        w_exp_arg;

    assign w_x         = 32'($signed(bus.lfsr_data) >>> 1);
    assign w_tmo       = (r_wait == WAIT_W'(EXP_TMO - 1));
    assign w_accept    = (r_exp_res > r_u);
    assign w_tries_inc = sat_inc_try(r_tries);
    assign w_exhaust   = (w_tries_inc == TRY_W'(MAX_TRIES));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.gen_en) w_next = DRAW_X;
            DRAW_X:   w_next = EXP_WAIT;
            EXP_WAIT: if (bus.exp_done || w_tmo) w_next = DRAW_U;
            DRAW_U:   w_next = CMP;
            CMP:      w_next = (w_accept || w_exhaust) ? OUT : DRAW_X;
            OUT:      if (bus.out_ready) w_next = bus.gen_en ? DRAW_X : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // exp_arg is bypassed in DRAW_X so the exp unit sees x in the exp_start cycle.
    always_comb begin
        w_lfsr_step = (r_state == DRAW_X) || (r_state == DRAW_U);
        w_exp_start = (r_state == DRAW_X);
        w_out_valid = (r_state == OUT);
        w_busy      = (r_state != IDLE);
        w_exp_arg   = (r_state == DRAW_X) ? w_x : r_exp_arg;
    end

    // A timed-out try forces the exp result to 0 so CMP always rejects it
    // while still drawing u, keeping two LFSR steps per try.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_arg  <= '0;
            r_exp_res  <= '0;
            r_u        <= '0;
            r_out_data <= '0;
            r_out_tmo  <= 1'b0;
            r_tries    <= '0;
            r_wait     <= '0;
        end else begin
            case (r_state)
                DRAW_X: begin
                    r_exp_arg <= w_x;
                    r_wait    <= '0;
                end
                EXP_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (bus.exp_done)
                        r_exp_res <= bus.exp_result;
                    else if (w_tmo)
                        r_exp_res <= '0;
                end
                DRAW_U: r_u <= uniform_from_lfsr(bus.lfsr_data);
                CMP: begin
                    if (w_accept) begin
                        r_out_data <= r_exp_arg;
                        r_out_tmo  <= 1'b0;
                    end else begin
                        r_tries <= w_tries_inc;
                        if (w_exhaust) begin
                            r_out_data <= '0;
                            r_out_tmo  <= 1'b1;
                        end
                    end
                end
                OUT: if (bus.out_ready) r_tries <= '0;
                default: ;
            endcase
        end
    end

    assign bus.lfsr_step   = w_lfsr_step;
    assign bus.exp_start   = w_exp_start;
    assign bus.exp_arg     = w_exp_arg;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_timeout = r_out_tmo;
    assign bus.busy        = w_busy;

`ifdef GAUSS_STATS_EN
    logic        w_st_accept;
    logic        w_st_reject;
    logic        w_st_timeout;
    logic [31:0] w_stat_accept;
    logic [31:0] w_stat_reject;
    logic [15:0] w_stat_timeout;

    assign w_st_accept  = (r_state == CMP) && w_accept;
    assign w_st_reject  = (r_state == CMP) && !w_accept;
    assign w_st_timeout = w_st_reject && w_exhaust;

    gauss_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .i_accept  (w_st_accept),
        .i_reject  (w_st_reject),
        .i_timeout (w_st_timeout),
        .o_accept  (w_stat_accept),
        .o_reject  (w_stat_reject),
        .o_timeout (w_stat_timeout)
    );

    assign bus.stat_accept  = w_stat_accept;
    assign bus.stat_reject  = w_stat_reject;
    assign bus.stat_timeout = w_stat_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gauss_sample_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_gauss_sample_ctrl                                                     |
// | Directed bench with LFSR word table and latency-programmable exp model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gauss_sample_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gauss_if bus ();

    logic        tb_gen_en     = 1'b0;
    logic        tb_out_ready  = 1'b0;
    logic        tb_exp_done   = 1'b0;
    logic [31:0] tb_exp_result = 32'h0;
    logic [31:0] lfsr_tab [0:255];
    logic [7:0]  lfsr_idx      = 8'd0;

    assign bus.gen_en     = tb_gen_en;
    assign bus.out_ready  = tb_out_ready;
    assign bus.exp_done   = tb_exp_done;
    assign bus.exp_result = tb_exp_result;
    assign bus.lfsr_data  = lfsr_tab[lfsr_idx];

    int          exp_lat = 3;
    logic [31:0] exp_val = 32'h1000_0000;
    logic        exp_en  = 1'b1;
    int          exp_cnt = 0;
    logic        step_pend  = 1'b0;
    logic        start_pend = 1'b0;

    int total = 0;
    int bad   = 0;

    gauss_sample_ctrl #(
        .MAX_TRIES (4),
        .EXP_TMO   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Models observe the DUT mid-cycle and react just after the next rising edge.
    always @(negedge clk) begin
        step_pend  = bus.lfsr_step;
        start_pend = bus.exp_start;
    end

    always @(posedge clk) begin
        #1;
        tb_exp_done = 1'b0;
        if (step_pend)
            lfsr_idx = lfsr_idx + 8'd1;
        if (start_pend)
            exp_cnt = exp_lat;
        if (exp_cnt > 0) begin
            exp_cnt = exp_cnt - 1;
            if (exp_cnt == 0 && exp_en) begin
                tb_exp_done   = 1'b1;
                tb_exp_result = exp_val;
            end
        end
    end

    task automatic put_word(input int k, input logic [31:0] w);
        lfsr_tab[8'(int'(lfsr_idx) + k)] = w;
    endtask

    task automatic handshake_to_idle();
        tb_gen_en    = 1'b0;
        tb_out_ready = 1'b1;
        @(negedge clk);
        tb_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        tb_gen_en    = 1'b0;
        tb_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.out_valid, bus.lfsr_step, bus.exp_start, bus.out_timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.busy, bus.out_valid, bus.lfsr_step, bus.exp_start, bus.out_timeout});
        end
        total++;
        if ({bus.exp_arg, bus.out_data} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: got arg=%h data=%h want 0", bus.exp_arg, bus.out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_timeout_tries();
        int steps = 0;
        int c = 0;
        exp_lat = 2;
        exp_val = 32'h0;
        exp_en  = 1'b1;
        for (int k = 0; k < 10; k++)
            put_word(k, 32'h9E37_79B9 ^ 32'(k));
        tb_gen_en = 1'b1;
        @(negedge clk);
        tb_gen_en = 1'b0;
        while (!bus.out_valid && c < 200) begin
            if (bus.lfsr_step) steps++;
            @(negedge clk);
            c++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL tmo_valid: got %b want 1 after %0d cycles", bus.out_valid, c);
        end
        total++;
        if (steps !== 8) begin
            bad++;
            $display("FAIL tmo_steps: got %0d want 8", steps);
        end
        total++;
        if ({bus.out_timeout, bus.out_data} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL tmo_result: got tmo=%b data=%h want tmo=1 data=0", bus.out_timeout, bus.out_data);
        end
        handshake_to_idle();
    endtask

    task automatic test_first_accept();
        int c = 0;
        exp_lat = 3;
        exp_val = 32'h1000_0000;
        exp_en  = 1'b1;
        put_word(0, 32'h4000_0000);
        put_word(1, 32'h1000_0000);
        tb_gen_en = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.exp_start, bus.lfsr_step} !== 3'b111 || bus.exp_arg !== 32'h2000_0000) begin
            bad++;
            $display("FAIL accept_draw_x: got flags=%b arg=%h want 111 20000000",
                     {bus.busy, bus.exp_start, bus.lfsr_step}, bus.exp_arg);
        end
        tb_gen_en = 1'b0;
        while (!bus.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c !== 6) begin
            bad++;
            $display("FAIL accept_latency: got %0d want 6", c);
        end
        total++;
        if ({bus.out_timeout, bus.out_data} !== {1'b0, 32'h2000_0000}) begin
            bad++;
            $display("FAIL accept_data: got tmo=%b data=%h want tmo=0 data=20000000",
                     bus.out_timeout, bus.out_data);
        end
        handshake_to_idle();
        total++;
        if ({bus.busy, bus.out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL accept_idle: got %b want 00", {bus.busy, bus.out_valid});
        end
    endtask

    task automatic test_stats();
`ifdef GAUSS_STATS_EN
        total++;
        if (bus.stat_reject !== 32'd4 || bus.stat_timeout !== 16'd1 || bus.stat_accept !== 32'd1) begin
            bad++;
            $display("FAIL stats: got rej=%0d tmo=%0d acc=%0d want 4 1 1",
                     bus.stat_reject, bus.stat_timeout, bus.stat_accept);
        end
`endif
    endtask

    task automatic test_equal_reject();
        int steps = 0;
        int starts = 0;
        int c = 0;
        exp_lat = 1;
        exp_val = 32'h0800_0000;
        exp_en  = 1'b1;
        put_word(0, 32'h0000_0002);
        put_word(1, 32'h8000_0000);
        put_word(2, 32'hFFFF_FFF0);
        put_word(3, 32'h4000_0000);
        tb_gen_en = 1'b1;
        @(negedge clk);
        tb_gen_en = 1'b0;
        while (!bus.out_valid && c < 60) begin
            if (bus.lfsr_step) steps++;
            if (bus.exp_start) starts++;
            @(negedge clk);
            c++;
        end
        total++;
        if (steps !== 4 || starts !== 2) begin
            bad++;
            $display("FAIL equal_tries: got steps=%0d starts=%0d want 4 2", steps, starts);
        end
        total++;
        if ({bus.out_valid, bus.out_timeout, bus.out_data} !== {2'b10, 32'hFFFF_FFF8}) begin
            bad++;
            $display("FAIL equal_result: got v=%b tmo=%b data=%h want v=1 tmo=0 data=fffffff8",
                     bus.out_valid, bus.out_timeout, bus.out_data);
        end
        handshake_to_idle();
    endtask

    task automatic test_back_to_back();
        int c = 0;
        exp_lat = 2;
        exp_val = 32'h1000_0000;
        exp_en  = 1'b1;
        put_word(0, 32'h2000_0000);
        put_word(1, 32'h0000_0000);
        put_word(2, 32'h6000_0000);
        put_word(3, 32'h0000_0010);
        tb_gen_en = 1'b1;
        while (!bus.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({bus.out_valid, bus.lfsr_step, bus.out_data} !== {2'b10, 32'h1000_0000}) begin
                bad++;
                $display("FAIL hold_%0d: got v=%b step=%b data=%h want v=1 step=0 data=10000000",
                         i, bus.out_valid, bus.lfsr_step, bus.out_data);
            end
            @(negedge clk);
        end
        tb_out_ready = 1'b1;
        @(negedge clk);
        tb_out_ready = 1'b0;
        tb_gen_en    = 1'b0;
        total++;
        if ({bus.exp_start, bus.lfsr_step, bus.out_valid} !== 3'b110 || bus.exp_arg !== 32'h3000_0000) begin
            bad++;
            $display("FAIL b2b_draw_x: got flags=%b arg=%h want 110 30000000",
                     {bus.exp_start, bus.lfsr_step, bus.out_valid}, bus.exp_arg);
        end
        c = 0;
        while (!bus.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (bus.out_data !== 32'h3000_0000 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got v=%b data=%h want v=1 data=30000000", bus.out_valid, bus.out_data);
        end
        handshake_to_idle();
    endtask

    task automatic test_exp_timeout_reset();
        int first_step = -1;
        int restart    = -1;
        exp_en = 1'b0;
        put_word(0, 32'h0000_0100);
        put_word(1, 32'h0000_0000);
        put_word(2, 32'h0000_0200);
        put_word(3, 32'h0000_0000);
        tb_gen_en = 1'b1;
        @(negedge clk);
        tb_gen_en = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.lfsr_step && first_step < 0) first_step = c;
            if (bus.exp_start && restart < 0) restart = c;
        end
        total++;
        if (first_step !== 9 || restart !== 11) begin
            bad++;
            $display("FAIL exp_tmo_timing: got u_draw=%0d retry=%0d want 9 11", first_step, restart);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL exp_tmo_busy: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.out_valid, bus.lfsr_step, bus.exp_start, bus.out_timeout} !== 5'b0 ||
            {bus.exp_arg, bus.out_data} !== 64'h0) begin
            bad++;
            $display("FAIL rst_in_wait: got flags=%b arg=%h data=%h want 0",
                     {bus.busy, bus.out_valid, bus.lfsr_step, bus.exp_start, bus.out_timeout},
                     bus.exp_arg, bus.out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_stays_idle: got %b want 0", bus.busy);
        end
        exp_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            lfsr_tab[i] = 32'h0;
        test_reset();
        test_timeout_tries();
        test_first_accept();
        test_stats();
        test_equal_reject();
        test_back_to_back();
        test_exp_timeout_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
